// File: rtl/aurora_tx_arbiter.sv
// Round-robin burst arbiter feeding one Aurora TX FIFO read port from N_SRC source FIFOs.
// Define AURORA_TX_ARB_TRAILER_EN to append an XOR checksum trailer word to every burst.
module aurora_tx_arbiter #(
    parameter int         N_SRC     = 4,
    parameter int         BURST_LEN = 16,
    parameter int         CNT_W     = 10,
    parameter logic [7:0] SYNC      = 8'hA5
) (
    input  logic                   user_clk,
    input  logic                   RESET_N,
    input  logic                   CHANNEL_UP,
    input  logic [N_SRC-1:0]       src_en_i,
    input  logic [32*N_SRC-1:0]    src_dat_i,
    input  logic [N_SRC-1:0]       src_empty_i,
    input  logic [CNT_W*N_SRC-1:0] src_cnt_i,
    output logic [N_SRC-1:0]       src_rd_o,
    output logic [31:0]            aur_dat_o,
    output logic                   aur_empty_o,
    input  logic                   aur_rd_i,
    output logic [N_SRC-1:0]       grant_o,
    output logic                   busy_o,
    output logic                   abort_o,
    output logic [15:0]            burst_cnt_o
);

    localparam int               DATA_W      = 32;
    localparam int               IDX_W       = $clog2(N_SRC);
    localparam logic [CNT_W-1:0] BURST_THR   = CNT_W'(BURST_LEN);
    localparam logic [7:0]       BURST_LEN_B = 8'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
`ifdef AURORA_TX_ARB_TRAILER_EN
        DATA = 2'd2,
        TRL  = 2'd3
`else
        DATA = 2'd2
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   gidx, rr_ptr, pick;
    logic               pick_vld;
    logic [N_SRC-1:0]   elig;
    logic [DATA_W-1:0]  src_word [N_SRC];
    logic [7:0]         seq, wcnt;
    logic               link_empty, pop;
`ifdef AURORA_TX_ARB_TRAILER_EN
    logic [DATA_W-1:0]  xor_acc;
`endif

    // First requester strictly after the last grant, wrapping modulo N_SRC; MSB flags a hit.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_SRC-1:0] req,
                                               input logic [IDX_W-1:0] last);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % N_SRC);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < N_SRC; k++) begin
            elig[k]     = CHANNEL_UP & src_en_i[k] & (src_cnt_i[k*CNT_W +: CNT_W] >= BURST_THR);
            src_word[k] = src_dat_i[k*DATA_W +: DATA_W];
        end
    end

    assign {pick_vld, pick} = rr_pick(elig, rr_ptr);

    always_ff @(posedge user_clk or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Losing the channel overrides any pop, so an abort never completes a burst.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = HDR;
            HDR: begin
                if (!CHANNEL_UP) state_nxt = IDLE;
                else if (pop)    state_nxt = DATA;
            end
            DATA: begin
                if (!CHANNEL_UP) state_nxt = IDLE;
`ifdef AURORA_TX_ARB_TRAILER_EN
                else if (pop && wcnt == 8'd1) state_nxt = TRL;
            end
            TRL: begin
                if (!CHANNEL_UP) state_nxt = IDLE;
                else if (pop)    state_nxt = IDLE;
`else
                else if (pop && wcnt == 8'd1) state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        aur_dat_o  = '0;
        link_empty = 1'b1;
        src_rd_o   = '0;
        case (state)
            HDR: begin
                aur_dat_o  = {SYNC, 8'(gidx), seq, BURST_LEN_B};
                link_empty = ~CHANNEL_UP;
            end
            DATA: begin
                aur_dat_o      = src_word[gidx];
                link_empty     = src_empty_i[gidx] | ~CHANNEL_UP;
                src_rd_o[gidx] = aur_rd_i & ~link_empty;
            end
`ifdef AURORA_TX_ARB_TRAILER_EN
            TRL: begin
                aur_dat_o  = xor_acc;
                link_empty = ~CHANNEL_UP;
            end
`endif
            default: ;
        endcase
    end

    assign aur_empty_o = link_empty;
    assign pop         = aur_rd_i & ~link_empty;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge user_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            gidx        <= '0;
            rr_ptr      <= IDX_W'(N_SRC - 1);
            grant_o     <= '0;
            seq         <= '0;
            wcnt        <= '0;
            burst_cnt_o <= '0;
            abort_o     <= 1'b0;
`ifdef AURORA_TX_ARB_TRAILER_EN
            xor_acc     <= '0;
`endif
        end else begin
            abort_o <= (state != IDLE) && !CHANNEL_UP;
            if (state != IDLE && !CHANNEL_UP) begin
                grant_o <= '0;
            end else begin
                case (state)
                    IDLE: if (pick_vld) begin
                        gidx    <= pick;
                        rr_ptr  <= pick;
                        grant_o <= N_SRC'(1) << pick;
                    end
                    HDR: begin
`ifdef AURORA_TX_ARB_TRAILER_EN
                        xor_acc <= '0;
`endif
                        if (pop) begin
                            seq  <= seq + 8'd1;
                            wcnt <= BURST_LEN_B;
                        end
                    end
                    DATA: if (pop) begin
                        wcnt <= wcnt - 8'd1;
`ifdef AURORA_TX_ARB_TRAILER_EN
                        xor_acc <= xor_acc ^ aur_dat_o;
`else
                        if (wcnt == 8'd1) begin
                            burst_cnt_o <= burst_cnt_o + 16'd1;
                            grant_o     <= '0;
                        end
`endif
                    end
`ifdef AURORA_TX_ARB_TRAILER_EN
                    TRL: if (pop) begin
                        burst_cnt_o <= burst_cnt_o + 16'd1;
                        grant_o     <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: queue-modelled source FIFOs and a burst-level link stream model.
module tb_aurora_tx_arbiter;

    localparam int N  = 4;
    localparam int BL = 16;
    localparam int CW = 10;
`ifdef AURORA_TX_ARB_TRAILER_EN
    localparam int L = BL + 2;
`else
    localparam int L = BL + 1;
`endif

    logic              user_clk = 1'b0;
    logic              RESET_N, CHANNEL_UP, aur_rd_i;
    logic [N-1:0]      src_en_i, src_empty_i, src_rd_o, grant_o;
    logic [32*N-1:0]   src_dat_i;
    logic [CW*N-1:0]   src_cnt_i;
    logic [31:0]       aur_dat_o;
    logic              aur_empty_o, busy_o, abort_o;
    logic [15:0]       burst_cnt_o;

    aurora_tx_arbiter #(.N_SRC(N), .BURST_LEN(BL), .CNT_W(CW), .SYNC(8'hA5)) dut (
        .user_clk(user_clk), .RESET_N(RESET_N), .CHANNEL_UP(CHANNEL_UP),
        .src_en_i(src_en_i), .src_dat_i(src_dat_i), .src_empty_i(src_empty_i),
        .src_cnt_i(src_cnt_i), .src_rd_o(src_rd_o), .aur_dat_o(aur_dat_o),
        .aur_empty_o(aur_empty_o), .aur_rd_i(aur_rd_i), .grant_o(grant_o),
        .busy_o(busy_o), .abort_o(abort_o), .burst_cnt_o(burst_cnt_o)
    );

    always #5 user_clk = ~user_clk;

    logic [31:0] q  [N][$];
    logic [31:0] mq [N][$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    logic [N-1:0] hold;
    bit          rd_random;
    int          mrr, mseq;
    int          checks, errors;
    logic        s_empty, s_abort, s_busy;
    logic [N-1:0] s_rd, s_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_srcs();
        for (int k = 0; k < N; k++) begin
            src_empty_i[k]          = (q[k].size() == 0) || hold[k];
            src_dat_i[k*32 +: 32]   = (q[k].size() > 0) ? q[k][0] : 32'h0;
            src_cnt_i[k*CW +: CW]   = CW'(q[k].size());
        end
    endtask

    task automatic add_src(input int k, input logic [31:0] w);
        q[k].push_back(w);
        mq[k].push_back(w);
    endtask

    // One clock: sample at the falling edge, then apply source pops just after the rising edge.
    task automatic tick();
        @(negedge user_clk);
        s_empty = aur_empty_o; s_rd = src_rd_o; s_abort = abort_o;
        s_grant = grant_o;     s_busy = busy_o;
        if (aur_rd_i && !aur_empty_o) got.push_back(aur_dat_o);
        @(posedge user_clk);
        #1;
        for (int k = 0; k < N; k++)
            if (s_rd[k] && q[k].size() > 0) void'(q[k].pop_front());
        if (rd_random) aur_rd_i = ($urandom_range(3) != 0);
        drive_srcs();
    endtask

    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (got.size() < target && n < budget) begin
            tick();
            n++;
        end
        check("timeout", 32'(got.size() >= target), 32'd1);
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] req);
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (last + i) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // Whole-burst model: keep granting eligible sources round-robin and append their link words.
    task automatic model_drain();
        logic [N-1:0] req;
        logic [31:0]  w, x;
        int g;
        for (int guard = 0; guard < 64; guard++) begin
            for (int k = 0; k < N; k++)
                req[k] = CHANNEL_UP && src_en_i[k] && (mq[k].size() >= BL);
            g = rr_next(mrr, req);
            if (g < 0) break;
            exp_q.push_back({8'hA5, 8'(g), 8'(mseq), 8'(BL)});
            x = 32'h0;
            for (int i = 0; i < BL; i++) begin
                w = mq[g].pop_front();
                exp_q.push_back(w);
                x = x ^ w;
            end
`ifdef AURORA_TX_ARB_TRAILER_EN
            exp_q.push_back(x);
`endif
            mseq = (mseq + 1) % 256;
            mrr  = g;
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge user_clk);
        #1;
        RESET_N  = 1'b0;
        aur_rd_i = 1'b1;
        #1;
        check("rst_empty", 32'(aur_empty_o), 32'd1);
        check("rst_dat", aur_dat_o, 32'h0);
        check("rst_rd", 32'(src_rd_o), 32'h0);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_abort", 32'(abort_o), 32'h0);
        check("rst_bcnt", 32'(burst_cnt_o), 32'h0);
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            mq[k].delete();
        end
        got.delete();
        exp_q.delete();
        hold = '0;
        mrr  = N - 1;
        mseq = 0;
        drive_srcs();
        repeat (2) @(posedge user_clk);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic abort_run(input int drop_at);
        do_reset();
        CHANNEL_UP = 1'b1;
        for (int i = 0; i < BL; i++) begin
            add_src(0, $urandom);
            add_src(1, $urandom);
        end
        drive_srcs();
        run_until(drop_at, 200);
        CHANNEL_UP = 1'b0;
        tick();
        check("ab_same_empty", 32'(s_empty), 32'd1);
        check("ab_same_rd", 32'(s_rd), 32'h0);
        tick();
        check("ab_pulse", 32'(s_abort), 32'd1);
        check("ab_grant", 32'(s_grant), 32'h0);
        check("ab_busy", 32'(s_busy), 32'h0);
        tick();
        check("ab_pulse_end", 32'(s_abort), 32'd0);
        repeat (4) tick();
        check("ab_down_busy", 32'(s_busy), 32'h0);
        check("ab_down_grant", 32'(s_grant), 32'h0);
        check("ab_bcnt", 32'(burst_cnt_o), 32'h0);
        exp_q.push_back({8'hA5, 8'h00, 8'h00, 8'(BL)});
        for (int i = 0; i < drop_at - 1; i++) exp_q.push_back(mq[0].pop_front());
        mseq = 1;
        mrr  = 0;
        check_stream("abort");
        CHANNEL_UP = 1'b1;
        model_drain();
        run_until(exp_q.size(), 200);
        check_stream("ab_resume");
        check("ab_resume_bcnt", 32'(burst_cnt_o), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        checks = 0; errors = 0;
        RESET_N = 1'b0; CHANNEL_UP = 1'b0; aur_rd_i = 1'b0; src_en_i = '1;
        hold = '0; rd_random = 1'b0;
        src_dat_i = '0; src_empty_i = '1; src_cnt_i = '0;
        do_reset();
        CHANNEL_UP = 1'b1;

        // Single source, counting data, continuous reads.
        for (int i = 0; i < BL; i++) add_src(0, 32'(i));
        drive_srcs();
        model_drain();
        repeat (3) tick();
        check("t1_grant", 32'(s_grant), 32'h1);
        check("t1_busy", 32'(s_busy), 32'h1);
        run_until(L, 200);
        check("t1_hdr", (got.size() > 0) ? got[0] : 32'hx, 32'hA500_0010);
        check("t1_bcnt", 32'(burst_cnt_o), 32'd1);
        check("t1_grant_idle", 32'(grant_o), 32'h0);
        check("t1_busy_idle", 32'(busy_o), 32'h0);
        check_stream("t1");
        for (int i = 0; i < BL; i++) add_src(0, $urandom);
        drive_srcs();
        model_drain();
        run_until(L, 200);
        check("t1b_hdr", (got.size() > 0) ? got[0] : 32'hx, 32'hA500_0110);
        check_stream("t1b");
        check("t1b_bcnt", 32'(burst_cnt_o), 32'd2);

        // Reset in the middle of a burst.
        for (int i = 0; i < BL; i++) add_src(3, $urandom);
        drive_srcs();
        run_until(5, 100);
        do_reset();

        // All four sources eligible, random read throttling.
        rd_random = 1'b1;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < BL; i++) add_src(k, $urandom);
        for (int i = 0; i < BL; i++) add_src(0, $urandom);
        drive_srcs();
        model_drain();
        run_until(exp_q.size(), 1000);
        for (int b = 0; b < 5; b++) begin
            if (b * L < got.size()) begin
                w = got[b*L];
                check($sformatf("t2_id%0d", b), 32'(w[23:16]), 32'(b % N));
                check($sformatf("t2_seq%0d", b), 32'(w[15:8]), 32'(b));
            end
        end
        check_stream("t2");
        check("t2_bcnt", 32'(burst_cnt_o), 32'd5);
        rd_random = 1'b0;
        aur_rd_i  = 1'b1;

        // Source one word short of a burst is skipped until it fills.
        do_reset();
        for (int i = 0; i < BL; i++) begin
            add_src(0, $urandom);
            add_src(2, $urandom);
        end
        for (int i = 0; i < BL - 1; i++) add_src(1, $urandom);
        drive_srcs();
        model_drain();
        run_until(exp_q.size(), 300);
        repeat (4) tick();
        check("t3_skip_busy", 32'(s_busy), 32'h0);
        check("t3_bcnt", 32'(burst_cnt_o), 32'd2);
        check_stream("t3a");
        add_src(1, $urandom);
        drive_srcs();
        model_drain();
        run_until(exp_q.size(), 100);
        w = (got.size() > 0) ? got[0] : 32'hx;
        check("t3_id1", 32'(w[23:16]), 32'd1);
        check_stream("t3b");

        // Source runs dry after word 5 for 10 cycles; enable dropped meanwhile.
        do_reset();
        for (int i = 0; i < BL; i++) add_src(0, $urandom);
        drive_srcs();
        model_drain();
        run_until(7, 100);
        hold[0]     = 1'b1;
        src_en_i[0] = 1'b0;
        drive_srcs();
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_empty%0d", i), 32'(s_empty), 32'd1);
            check($sformatf("t4_rd%0d", i), 32'(s_rd), 32'h0);
        end
        hold = '0;
        drive_srcs();
        run_until(L, 100);
        src_en_i = '1;
        check_stream("t4");
        check("t4_bcnt", 32'(burst_cnt_o), 32'd1);

        // Channel loss after data word 8, and together with the final pop.
        abort_run(10);
        abort_run(L - 1);

        // Walking-one data: trailer is the OR of all bits when enabled.
        do_reset();
        for (int i = 0; i < BL; i++) add_src(0, 32'h1 << i);
        drive_srcs();
        model_drain();
        run_until(L, 100);
        repeat (2) tick();
        check("t6_link_len", 32'(got.size()), 32'(L));
`ifdef AURORA_TX_ARB_TRAILER_EN
        check("t6_trailer", (got.size() > BL + 1) ? got[BL+1] : 32'hx, 32'h0000_FFFF);
`endif
        check_stream("t6");
        check("t6_bcnt", 32'(burst_cnt_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_tx_arbiter.md
Name: aurora_tx_arbiter

Overview:
- Shares one Aurora unit's TX FIFO read port (fifo_dat_i / fifo_empty_i / fifo_rd_o side) among N_SRC source FIFOs.
- Grants whole fixed-length bursts round-robin.
- Prefixes each burst with a header word carrying source ID and sequence number.
- Gated by CHANNEL_UP. Sits between the per-source data FIFOs and the Aurora unit, in the user_clk domain.

Parameters:
- N_SRC, 4: number of requesting source FIFOs (2..8).
- BURST_LEN, 16: data words per burst (1..255).
- CNT_W, 10: width of each source FIFO occupancy count.
- SYNC, 8'hA5: header sync byte.

Ports:
- user_clk  in  1  Aurora user clock; all logic is on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- CHANNEL_UP  in  1  Aurora channel status; arbitration is permitted only while high.
- src_en_i  in  N_SRC  per-source enable mask.
- src_dat_i  in  32*N_SRC  FWFT source data; source k occupies bits [32k+31:32k].
- src_empty_i  in  N_SRC  source FIFO empty flags.
- src_cnt_i  in  CNT_W*N_SRC  source FIFO occupancy counts.
- src_rd_o  out  N_SRC  source pop strobes.
- aur_dat_o  out  32  word presented to Aurora (to fifo_dat_i).
- aur_empty_o  out  1  to fifo_empty_i; 1 = nothing valid.
- aur_rd_i  in  1  from fifo_rd_o; pops the current word.
- grant_o  out  N_SRC  one-hot current grant; 0 when idle.
- busy_o  out  1  high in any state other than IDLE.
- abort_o  out  1  one-cycle pulse when a burst is aborted.
- burst_cnt_o  out  16  completed bursts; wraps at 16'hFFFF→0.

Behaviour:
- Reset values: FSM=IDLE, aur_empty_o=1, aur_dat_o=0, src_rd_o=0, grant_o=0, busy_o=0, abort_o=0, burst_cnt_o=0, seq=0, rr pointer=N_SRC-1.
- Eligibility:
  - Source k is eligible when src_en_i[k]=1, src_cnt_i[k] >= BURST_LEN, and CHANNEL_UP=1.
  - Ties are resolved round-robin, searching upward from rr pointer+1 with modulo N_SRC.
- IDLE:
  - If any source is eligible, register grant and header, update rr pointer to the granted index, then go to HDR on the next cycle.
  - Decision latency: 1 cycle after eligibility is seen.
  - Otherwise remain in IDLE.
- HDR:
  - aur_dat_o = {SYNC, 8-bit src id, seq[7:0], BURST_LEN[7:0]}; aur_empty_o=0.
  - On aur_rd_i: seq increments (wraps 255→0), word counter loads BURST_LEN, go to DATA.
- DATA:
  - Combinational passthrough: aur_dat_o = granted src_dat_i; aur_empty_o = granted src_empty_i; src_rd_o[g] = aur_rd_i & ~src_empty_i[g]. No data latency.
  - Each pop decrements the word counter.
  - The pop that takes the counter to 0 goes to IDLE (or TRL when the option is enabled), increments burst_cnt_o, and clears grant_o.
  - aur_rd_i while aur_empty_o=1 is ignored; no pop and no count.
- Source empty mid-burst: legal; aur_empty_o follows the source and the FSM waits in DATA.
- src_en_i deasserted mid-burst: the burst completes; the mask affects only arbitration.
- CHANNEL_UP falls in HDR, DATA or TRL:
  - Same cycle: aur_empty_o=1 and src_rd_o=0 (combinationally gated).
  - Next edge: FSM→IDLE, abort_o pulses 1 cycle, grant_o=0.
  - seq and burst_cnt_o are not changed.
  - Unsent words remain in the source; the receiver resynchronises on SYNC.
- Simultaneous CHANNEL_UP fall and final pop: the abort wins; no pop occurs and burst_cnt_o is unchanged.
- RESET_N asserted mid-burst: all state returns to reset values asynchronously; no pop is issued.

Optional Feature:
- Macro: AURORA_TX_ARB_TRAILER_EN.
- Defined:
  - A running XOR of every popped DATA word (cleared in HDR) is kept.
  - After the last DATA pop, the FSM enters TRL, presenting aur_dat_o = XOR value with aur_empty_o=0.
  - The pop in TRL goes to IDLE, and burst_cnt_o increments at that pop instead of at the last DATA pop.
  - Burst length on the link is BURST_LEN+2 words.
- Undefined: no TRL state and no XOR logic; burst length on the link is BURST_LEN+1 words.

Test Plan:
- Single source: src0 cnt=16, data 0..15, aur_rd_i held 1 → header 32'hA5_00_00_10 followed by 0..15; burst_cnt_o=1; grant_o back to 0; seq=1.
- All four sources cnt>=16, continuous reads → grant order 0,1,2,3,0; header IDs 00,01,02,03,00; seq 0..4.
- Source below threshold: src1 cnt=15 with others eligible → src1 is skipped; src1 is granted once its cnt reaches 16.
- src0 empties after word 5 for 10 cycles → aur_empty_o=1 for those cycles, no src_rd_o, burst resumes at word 6 and completes with 16 data words.
- CHANNEL_UP dropped after data word 8 → abort_o one pulse, aur_empty_o=1 the same cycle, burst_cnt_o unchanged, no grant while CHANNEL_UP=0.
- With AURORA_TX_ARB_TRAILER_EN, data 1,2,4,...,32768 → trailer word 32'h0000FFFF; 18 words on the link.
